// File: rtl/apb_requester_bridge_pkg.sv
// Shared types and defaults for the APB requester bridge.
//   apb_req_state_t     : requester FSM state encoding
//   APB_DATA_WIDTH      : the only supported APB data width
//   APB_DEFAULT_TIMEOUT : default ACCESS-phase abort limit in cycles
package apb_requester_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_req_state_t;

  localparam int APB_DATA_WIDTH      = 32;
  localparam int APB_DEFAULT_TIMEOUT = 256;

endpackage

// File: rtl/apb_requester_bridge.sv
// APB requester bridge: turns a valid/ready command stream into single APB
// transfers, one outstanding at a time, and returns read data / error status
// on a valid/ready response handshake. A per-transfer ACCESS-phase timeout
// aborts transfers to completers that never raise pready.
//
// Ports
//   clk, rst                     clock (also pclk), async active-high reset
//   cmd_valid/cmd_ready          command handshake (cmd_ready = IDLE)
//   cmd_write/cmd_addr/cmd_wdata command fields
//   rsp_valid/rsp_ready          response handshake, response held until taken
//   rsp_rdata/rsp_err/rsp_timeout response fields
//   psel/penable/pwrite/paddr/pwdata   APB request side
//   pready/prdata/pslverr        APB completer side
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a command; command fields latched on acceptance
// SETUP  | APB setup phase, psel=1 penable=0, one cycle
// ACCESS | APB access phase, psel=1 penable=1, waiting for pready/timeout
// RESP   | response presented, waiting for rsp_ready
module apb_requester_bridge
  import apb_requester_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = APB_DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  generate
    if (DATA_WIDTH != APB_DATA_WIDTH) begin : g_bad_width
      $error("apb_requester_bridge: DATA_WIDTH must be 32");
    end
  endgenerate

  // Counter must hold TIMEOUT_CYCLES; keep at least one bit when disabled.
  localparam int              CNT_W     = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int              TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_LAST_I);
  localparam bit              TO_EN     = (TIMEOUT_CYCLES > 0);

  apb_req_state_t   state, state_nxt;
  logic [CNT_W-1:0] to_cnt;
  logic             to_hit;

  // pready on the last allowed cycle takes priority over the abort.
  assign to_hit    = TO_EN && (to_cnt == TO_LAST) && !pready;
  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (pready || to_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs. psel/penable are decoded from the next state so they
  // line up with the state register; the async reset drops them immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      to_cnt      <= '0;
    end else begin
      psel    <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      penable <= (state_nxt == ACCESS);
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
            to_cnt <= '0;
          end
        end
        ACCESS: begin
          if (to_cnt != {CNT_W{1'b1}}) to_cnt <= to_cnt + CNT_W'(1);
          if (pready) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
          end else if (to_hit) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester_bridge.sv
// Self-checking bench for apb_requester_bridge (TIMEOUT_CYCLES=8).
// A behavioural completer with configurable wait states / error / never-ready
// answers the APB side; expected responses go into a scoreboard queue when a
// command is issued and are compared when the response handshake fires.
module tb_apb_requester_bridge;
  import apb_requester_bridge_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready  = 1'b0;
  logic [DW-1:0] prdata  = '0;
  logic          pslverr = 1'b0;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   sb_pushed = 0;
  int   rsp_seen = 0;
  int   cyc = 0;

  int   ws = 0;
  bit   never_ready = 1'b0;
  bit   err_mode = 1'b0;
  int   acc_cnt = 0;
  logic [DW-1:0] mem [logic [AW-1:0]];

  apb_requester_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Completer: answers on ACCESS cycle number ws (0-based), junk data otherwise.
  always @(negedge clk) begin
    if (psel && penable) begin
      if (!never_ready && acc_cnt == ws) begin
        pready  = 1'b1;
        pslverr = err_mode;
        if (err_mode)    prdata = 32'hDEAD_BEEF;
        else if (pwrite) prdata = 32'hFFFF_0000;
        else             prdata = mem.exists(paddr) ? mem[paddr] : '0;
        if (pwrite && !err_mode) mem[paddr] = pwdata;
      end else begin
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'hBAD0_0000;
      end
      acc_cnt++;
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = 32'h1234_5678;
      acc_cnt = 0;
    end
  end

  // Scoreboard pop, sampled between the negedge and the next posedge.
  always @(negedge clk) begin
    #2;
    if (!rst && rsp_valid && rsp_ready) begin
      checks++;
      rsp_seen++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b to=%b, required no response",
                 rsp_rdata, rsp_err, rsp_timeout);
      end else begin
        mon_e = sb_q.pop_front();
        if (rsp_rdata !== mon_e.rdata || rsp_err !== mon_e.err || rsp_timeout !== mon_e.to) begin
          errors++;
          $display("FAIL rsp_data: got rdata=%h err=%b to=%b, required rdata=%h err=%b to=%b",
                   rsp_rdata, rsp_err, rsp_timeout, mon_e.rdata, mon_e.err, mon_e.to);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  // Issue one command; returns at the negedge of the SETUP cycle.
  task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit expect_rsp, input logic [DW-1:0] er, input bit ee,
                      input bit et, output int acc_cyc);
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 30 && !cmd_ready; i++) @(negedge clk);
    acc_cyc = cyc;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept: got cmd_ready=%b, required 1", cmd_ready);
    end
    if (expect_rsp) begin
      e.rdata = er; e.err = ee; e.to = et;
      sb_q.push_back(e);
      sb_pushed++;
    end
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
  endtask

  // From SETUP negedge: counts ACCESS cycles, flags paddr/pwrite movement.
  task automatic count_access(input logic [AW-1:0] a, input bit w, output int n, output bit stable);
    n = 0; stable = 1'b1;
    @(negedge clk);
    while (psel && penable && n < 100) begin
      n++;
      if (paddr !== a || pwrite !== w) stable = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_rsp(input int budget);
    for (int i = 0; i < budget && !rsp_valid; i++) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_wait: got rsp_valid=%b within %0d cycles, required 1", rsp_valid, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got psel=%b pen=%b pwr=%b rv=%b err=%b to=%b, required all 0",
               psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout);
    end
    checks++;
    if (paddr !== '0 || pwdata !== '0 || rsp_rdata !== '0) begin
      errors++;
      $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h, required 0", paddr, pwdata, rsp_rdata);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_wait_write();
    int t;
    ws = 0; err_mode = 1'b0; never_ready = 1'b0; rsp_ready = 1'b1;
    send(1'b1, 16'h0020, 32'h5, 1'b1, 32'h0, 1'b0, 1'b0, t);
    checks++;
    if (psel !== 1'b1 || penable !== 1'b0) begin
      errors++;
      $display("FAIL write_setup_c1: got psel=%b penable=%b, required 1 0", psel, penable);
    end
    @(negedge clk);
    checks++;
    if (psel !== 1'b1 || penable !== 1'b1 || pwrite !== 1'b1 || paddr !== 16'h0020 || pwdata !== 32'h5) begin
      errors++;
      $display("FAIL write_access_c2: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h, required 1 1 1 0020 00000005",
               psel, penable, pwrite, paddr, pwdata);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || psel !== 1'b0 || penable !== 1'b0) begin
      errors++;
      $display("FAIL write_rsp_c3: got rv=%b psel=%b pen=%b, required 1 0 0", rsp_valid, psel, penable);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_idle_c4: got cmd_ready=%b rv=%b, required 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_wait_read();
    int t, n;
    bit st;
    ws = 3;
    send(1'b0, 16'h0020, 32'h0, 1'b1, 32'h5, 1'b0, 1'b0, t);
    count_access(16'h0020, 1'b0, n, st);
    checks++;
    if (n !== 4 || !st) begin
      errors++;
      $display("FAIL wait_read_access: got %0d cycles stable=%b, required 4 stable=1", n, st);
    end
    @(negedge clk);
    ws = 0;
  endtask

  task automatic test_slverr();
    int t, n;
    bit st;
    err_mode = 1'b1;
    send(1'b0, 16'h0001, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, t);
    count_access(16'h0001, 1'b0, n, st);
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL slverr_access: got %0d cycles, required 1", n);
    end
    @(negedge clk);
    err_mode = 1'b0;
  endtask

  task automatic test_timeout();
    int t, n;
    bit st;
    never_ready = 1'b1;
    send(1'b0, 16'h0040, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1, t);
    count_access(16'h0040, 1'b0, n, st);
    checks++;
    if (n !== TO || psel !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout_abort: got %0d cycles psel=%b rv=%b, required %0d 0 1", n, psel, rsp_valid, TO);
    end
    @(negedge clk);
    never_ready = 1'b0;
    ws = TO - 1;
    send(1'b0, 16'h0020, 32'h0, 1'b1, 32'h5, 1'b0, 1'b0, t);
    count_access(16'h0020, 1'b0, n, st);
    checks++;
    if (n !== TO || !st) begin
      errors++;
      $display("FAIL timeout_edge_ready: got %0d cycles stable=%b, required %0d 1", n, st, TO);
    end
    @(negedge clk);
    ws = 0;
  endtask

  task automatic test_back_to_back();
    int t0, t1, t2;
    send(1'b1, 16'h0100, 32'hA1A1_0001, 1'b1, 32'h0, 1'b0, 1'b0, t0);
    send(1'b1, 16'h0104, 32'hB2B2_0002, 1'b1, 32'h0, 1'b0, 1'b0, t1);
    send(1'b0, 16'h0100, 32'h0,          1'b1, 32'hA1A1_0001, 1'b0, 1'b0, t2);
    checks++;
    if (t1 - t0 !== 4 || t2 - t1 !== 4) begin
      errors++;
      $display("FAIL back_to_back_rate: got spacing %0d %0d, required 4 4", t1 - t0, t2 - t1);
    end
    wait_rsp(20);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int t;
    rsp_ready = 1'b0;
    send(1'b0, 16'h0104, 32'h0, 1'b1, 32'hB2B2_0002, 1'b0, 1'b0, t);
    wait_rsp(20);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hB2B2_0002 || cmd_ready !== 1'b0 || psel !== 1'b0) begin
        errors++;
        $display("FAIL hold_c%0d: got rv=%b rdata=%h cmd_ready=%b psel=%b, required 1 b2b20002 0 0",
                 i, rsp_valid, rsp_rdata, cmd_ready, psel);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: got cmd_ready=%b rv=%b, required 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    never_ready = 1'b1;
    send(1'b0, 16'h0020, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, t);
    @(negedge clk);
    checks++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      errors++;
      $display("FAIL midrst_in_access: got psel=%b pen=%b, required 1 1", psel, penable);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: got psel=%b pen=%b rv=%b, required 0 0 0", psel, penable, rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    never_ready = 1'b0;
    ws = 1;
    send(1'b0, 16'h0020, 32'h0, 1'b1, 32'h5, 1'b0, 1'b0, t);
    wait_rsp(20);
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() !== 0 || rsp_seen !== sb_pushed) begin
      errors++;
      $display("FAIL rsp_count: got %0d responses with %0d pending, required %0d and 0",
               rsp_seen, sb_q.size(), sb_pushed);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
